// File: rtl/spi_master_param_pkg.sv
// spi_master_pkg: FSM states, command encodings and frame-width helper
// shared by the spi_master_param files.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  // Serial frame is {cmd, addr, data}.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// spi_master_param_if: host request/response signals plus SPI pins.
// master = the SPI master block, slave = host register file and pin side.
interface spi_master_param_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 3,
  parameter int NUM_SS = 1
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic              tx_cmd;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic [SS_W-1:0]   ss_sel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [NUM_SS-1:0] spi_ss_n;

  modport master (
    input  start, tx_cmd, tx_addr, tx_data, ss_sel, spi_miso,
    output busy, done, rx_data, spi_sclk, spi_mosi, spi_ss_n
  );

  modport slave (
    output start, tx_cmd, tx_addr, tx_data, ss_sel, spi_miso,
    input  busy, done, rx_data, spi_sclk, spi_mosi, spi_ss_n
  );

endinterface

// File: rtl/spi_master_param_sclk_gen.sv
// spi_sclk_gen: SCLK divider. While en_i is high, SCLK toggles every CLK_DIV
// clk cycles starting low; rise_o/fall_o flag the cycle whose clock edge
// makes the toggle. Dropping en_i returns SCLK low and restarts the count.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  // Next-state for the half-period counter and SCLK level, plus edge strobes.
  always_comb begin
    tick   = en_i && (cnt_q == LAST);
    rise_o = tick && !sclk_q;
    fall_o = tick && sclk_q;
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      sclk_d = tick ? !sclk_q : sclk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: mode-0, MSB-first SPI master with {cmd, addr, data}
// frames, programmable SCLK divider, NUM_SS one-hot-low selects and a
// post-frame idle gap. Optional read-back capture is enabled by defining
// SPI_MASTER_RX_EN; without it spi_miso is ignored and rx_data is 0.
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 3,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 1,
  parameter int GAP_CYC = 2
) (
  input logic               clk,
  input logic               n_rst,
  spi_master_param_if.master bus
);

  localparam int FW      = frame_w(ADDR_W, DATA_W);
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BIT_W   = $clog2(FW + 1);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(FW);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic              busy_q;
  logic              done_q;
  logic              mosi_q;
  logic [NUM_SS-1:0] ss_n_q;
  logic [FW-1:0]     tx_sh_q;

  logic [DATA_W-1:0] data_fld;
  logic [FW-1:0]     frame;
  logic [NUM_SS-1:0] ss_dec;
  logic              sclk, rise, fall;
  logic              accept;

  // Build the outgoing frame and decode the requested slave select.
  always_comb begin
    data_fld = (bus.tx_cmd == CMD_RD) ? '0 : bus.tx_data;
    frame    = {bus.tx_cmd, bus.tx_addr, data_fld};
    ss_dec   = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (bus.ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
    end
  end

  assign accept = (state_q == ST_IDLE) && bus.start;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk    (clk),
    .n_rst  (n_rst),
    .en_i   (state_q == ST_SHIFT),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

`ifdef SPI_MASTER_RX_EN
  logic              cmd_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;

  // Shift MISO in on every SCLK rise; the newest DATA_W samples are the read data.
  always_ff @(posedge clk) begin
    if ((state_q == ST_SHIFT) && rise) rx_sh_q <= DATA_W'({rx_sh_q, bus.spi_miso});
  end

  assign bus.rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = bus.spi_miso;
  assign bus.rx_data = '0;
`endif

  // Outgoing shift register: loaded at accept, advanced on each SCLK fall.
  always_ff @(posedge clk) begin
    if (accept) tx_sh_q <= frame;
    else if ((state_q == ST_SHIFT) && fall) tx_sh_q <= tx_sh_q << 1;
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
`ifdef SPI_MASTER_RX_EN
      cmd_q     <= CMD_WR;
      rx_data_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_SETUP;
            cnt_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            ss_n_q  <= ss_dec;
            mosi_q  <= frame[FW-1];
`ifdef SPI_MASTER_RX_EN
            cmd_q   <= bus.tx_cmd;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt_q == DIV_LAST) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise) bit_q <= bit_q + 1'b1;
          if (fall) begin
            // Zeros shift in behind the frame, so MOSI returns low after the last bit.
            mosi_q <= tx_sh_q[FW-2];
            if (bit_q == BIT_ALL) state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == DIV_LAST) begin
            ss_n_q <= '1;
            done_q <= 1'b1;
            cnt_q  <= '0;
`ifdef SPI_MASTER_RX_EN
            if (cmd_q == CMD_RD) rx_data_q <= rx_sh_q;
`endif
            if (GAP_CYC == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          // start seen here is dropped; only IDLE accepts a new frame.
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.spi_sclk = sclk;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_ss_n = ss_n_q;

endmodule
